// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The request fields are held stable while mem_req is high. Read data is sampled when mem_ack is high.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MW-stage load/store unit: one memory access per accepted instruction over a req/ack bus.
// The access ends with a one-cycle valid pulse. err qualifies the pulse.
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      wdata,
    load_store_unit_if.master    bus,
    output logic                 valid,
    output logic [XLEN-1:0]      rdata,
    output logic                 err,
    output logic                 busy
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    function automatic logic req_legal(input logic ld, input logic [2:0] f3, input logic [1:0] lane);
        logic f3_ok;
        logic aligned;
        if (ld) begin
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        end else begin
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        case (f3[1:0])
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b1;
        endcase
        return f3_ok && aligned;
    endfunction

    function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [XLEN-1:0] d);
        logic [XLEN-1:0] byte_sh;
        logic [XLEN-1:0] half_sh;
        byte_sh = d >> {lane, 3'b000};
        half_sh = d >> {lane[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  return {24'h000000, byte_sh[7:0]};
            3'b001:  return {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  return {16'h0000, half_sh[15:0]};
            default: return d;
        endcase
    endfunction

    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (is_load ^ is_store)) begin
                    is_load_d   = is_load;
                    funct3_d    = funct3;
                    lane_d      = addr[1:0];
                    mem_we_d    = is_store;
                    mem_addr_d  = {addr[XLEN-1:2], 2'b00};
                    mem_be_d    = access_be(funct3, addr[1:0]);
                    mem_wdata_d = store_lanes(funct3, wdata);
                    cnt_d       = '0;
                    if (req_legal(is_load, funct3, addr[1:0])) begin
                        state_d   = ST_BUS;
                        mem_req_d = 1'b1;
                    end else begin
                        // Rejected before touching the bus; a store keeps the previous load result
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        if (is_load) begin
                            rdata_d = '0;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // An ack in the expiring cycle still counts as a normal completion
                if (bus.mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    if (is_load_q) begin
                        rdata_d = load_extract(funct3_q, lane_q, bus.mem_rdata);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (TO_EN && (cnt_inc_s == TO_LIMIT)) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            valid_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign valid         = valid_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit (TIMEOUT_CYCLES=4): a bus responder acks after a programmed count.
// A scoreboard queue checks each valid pulse.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        valid;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit_if #(.XLEN(32)) bus_if ();

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_load  (is_load),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .bus      (bus_if.master),
        .valid    (valid),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_at;   // BUS cycle in which mem_ack is raised, 0 = never
        logic [31:0] rd_in;
        int          exp_req;  // number of cycles mem_req must be high
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        chk_rd;
        logic        exp_err;
        logic        hold;     // keep start high through BUS/DONE
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                                input logic [31:0] rd_in, input int exp_req, input logic [3:0] exp_be,
                                input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                                input logic chk_rd, input logic exp_err, input logic hold);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.ack_at = ack_at; v.rd_in = rd_in;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wd = exp_wd; v.exp_rd = exp_rd;
        v.chk_rd = chk_rd; v.exp_err = exp_err; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   req_cycles;
        int   cyc;
        bit   got;
        @(negedge clk);
        start = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
        e.rd = v.exp_rd; e.chk_rd = v.chk_rd; e.e = v.exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        if (!v.hold) begin
            start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        end
        req_cycles = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            if (bus_if.mem_req) begin
                req_cycles++;
                chk($sformatf("v%0d mem_addr", idx), bus_if.mem_addr, {v.a[31:2], 2'b00});
                chk($sformatf("v%0d mem_we", idx), {31'd0, bus_if.mem_we}, {31'd0, v.st});
                if (v.st || v.f3 == 3'b010) begin
                    chk($sformatf("v%0d mem_be", idx), {28'd0, bus_if.mem_be}, {28'd0, v.exp_be});
                end
                if (v.st) begin
                    chk($sformatf("v%0d mem_wdata", idx), bus_if.mem_wdata, v.exp_wd);
                end
                if (req_cycles == v.ack_at) begin
                    bus_if.mem_ack   = 1'b1;
                    bus_if.mem_rdata = v.rd_in;
                end
            end
            if (valid) begin
                got = 1'b1;
                start = 1'b0; is_load = 1'b0; is_store = 1'b0;
                if (sb_q.size() == 0) begin
                    chk($sformatf("v%0d unexpected valid", idx), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, e.e});
                    if (e.chk_rd) begin
                        chk($sformatf("v%0d rdata", idx), rdata, e.rd);
                    end
                end
            end
            @(negedge clk);
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = 32'h0000_0000;
            cyc++;
        end
        if (!got) begin
            chk($sformatf("v%0d valid never seen", idx), 32'd0, 32'd1);
        end
        chk($sformatf("v%0d mem_req cycles", idx), req_cycles, v.exp_req);
        chk($sformatf("v%0d valid one cycle", idx), {31'd0, valid}, 32'd0);
        chk($sformatf("v%0d busy after done", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        //                ld    st    f3      addr           wdata          ack rd_in          req be       exp_wd         exp_rd         chk   err   hold
        vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,          2, 32'hDEAD_BEEF, 2, 4'b1111, 32'h0,          32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,          1, 32'h80AA_5511, 1, 4'b1000, 32'h0,          32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,          1, 32'h80AA_5511, 1, 4'b1000, 32'h0,          32'h0000_0080, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,          1, 32'h80AA_5511, 1, 4'b1100, 32'h0,          32'hFFFF_80AA, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234,  1, 32'h0,         1, 4'b1100, 32'h1234_1234,  32'hFFFF_80AA, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,          1, 32'h0,         0, 4'b1111, 32'h0,          32'h0,         1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,          1, 32'h0,         0, 4'b1111, 32'h0,          32'h0,         1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,          0, 32'h0,         4, 4'b1111, 32'h0,          32'h0000_0000, 1'b1, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,          4, 32'h1234_5678, 4, 4'b1111, 32'h0,          32'h1234_5678, 1'b1, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_0401, 32'h0000_00A5,  1, 32'h0,         1, 4'b0010, 32'hA5A5_A5A5,  32'h1234_5678, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D,  3, 32'h0,         3, 4'b1111, 32'hCAFE_F00D,  32'h1234_5678, 1'b1, 1'b0, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,          1, 32'h80AA_5511, 1, 4'b1100, 32'h0,          32'h0000_80AA, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,          1, 32'h80AA_5511, 1, 4'b0001, 32'h0,          32'h0000_0011, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h0,          1, 32'h0,         0, 4'b0001, 32'h0,          32'h0,         1'b0, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'h0,          1, 32'h0,         0, 4'b0011, 32'h0,          32'h0,         1'b0, 1'b1, 1'b0);

        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;
        #12;
        chk("reset mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // start with neither or both direction bits is not an instruction
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        chk("both ld/st busy", {31'd0, busy}, 32'd0);
        is_load = 1'b0; is_store = 1'b0;
        @(negedge clk);
        chk("neither ld/st busy", {31'd0, busy}, 32'd0);
        chk("neither ld/st mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        start = 1'b0;

        // asynchronous reset in the middle of a bus access
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0;
        chk("pre-reset mem_req", {31'd0, bus_if.mem_req}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset valid", {31'd0, valid}, 32'd0);
        chk("async reset rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 100);

        if (sb_q.size() != 0) begin
            chk("scoreboard drained", sb_q.size(), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage data-memory access unit in the MW stage.
- Issues loads and stores to data memory over a req/ack handshake.
- Aligns write data and byte enables; extracts and sign/zero-extends load data.
- Produces `valid`, which the forwarding/hazard logic uses to hold the load-use stall until load data is available.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT_CYCLES, 16, max cycles in BUS without mem_ack before error; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  MW-stage memory instruction present; sampled only in IDLE
is_load  input  1  instruction is a load (opcode 0000011)
is_store  input  1  instruction is a store (opcode 0100011)
funct3  input  3  access size/sign from instruction bits [14:12]
addr  input  XLEN  effective byte address
wdata  input  XLEN  store data (rs2 value)
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  XLEN  lane-replicated store data
mem_ack  input  1  bus accepts/completes transfer this cycle
mem_rdata  input  XLEN  read data, valid when mem_ack=1
valid  output  1  one-cycle pulse: access complete; rdata valid for loads
rdata  output  XLEN  extended load result
err  output  1  qualifies valid: misaligned, illegal funct3 or timeout
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs, latched request fields and timeout counter = 0. Takes effect immediately, including mid-BUS: mem_req drops without waiting for ack.
- FSM states: IDLE, BUS, DONE.
- IDLE, accept condition: start=1 and (is_load xor is_store). On accept, latch addr, funct3, wdata and direction.
  - Request legal and aligned -> BUS.
  - Otherwise -> DONE with err=1; no bus access.
- IDLE, non-accept: start with neither or both of is_load/is_store is ignored.
- Illegal funct3:
  - loads: anything other than 000, 001, 010, 100, 101;
  - stores: anything other than 000, 001, 010.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- BUS:
  - mem_req=1; mem_we, mem_addr, mem_be, mem_wdata driven from registers and stable for the whole state.
  - mem_ack=1 -> capture extended load data (loads), go to DONE.
  - Timeout counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES (≠0) -> DONE with err=1, rdata=0, mem_req dropped.
  - mem_ack arriving in the same cycle the counter would expire wins (normal completion).
- DONE: valid=1 for exactly one cycle, then IDLE. start in DONE or BUS is ignored. Minimum request-to-valid latency is 3 cycles (accept, BUS with ack, DONE).
- rdata/err: hold their values until the next DONE. For stores, rdata is unchanged.
- Byte enables:
  - SB: 4'b0001 << addr[1:0]
  - SH: 4'b0011 << {addr[1],1'b0}
  - SW: 4'b1111
- mem_wdata:
  - SB: byte replicated ×4
  - SH: halfword replicated ×2
  - SW: as-is
- Load extract: select lane by addr[1:0] from mem_rdata.
  - LB/LH: sign-extend
  - LBU/LHU: zero-extend
  - LW: whole word
- valid is low in IDLE and BUS, so a pending load-use hazard stalls until DONE.
- busy=1 in BUS and DONE.

Test Plan:
1. LW addr=0x0000_0100, mem_ack after 2 BUS cycles with mem_rdata=0xDEADBEEF -> mem_req high 2 cycles, mem_addr=0x100, mem_be=4'hF, mem_we=0; next cycle valid=1, rdata=0xDEADBEEF, err=0; valid 1 cycle only.
2. LB addr=0x103, mem_rdata=0x80AA_5511 -> rdata=0xFFFF_FF80; repeat as LBU -> rdata=0x0000_0080; LH addr=0x102 -> 0xFFFF_80AA.
3. SH addr=0x202, wdata=0x0000_1234, ack immediately -> mem_we=1, mem_addr=0x200, mem_be=4'b1100, mem_wdata=0x1234_1234; valid pulse, err=0, rdata unchanged.
4. LW addr=0x101 -> no mem_req ever; next cycle valid=1, err=1; likewise load funct3=011 -> err=1.
5. TIMEOUT_CYCLES=4, LW with mem_ack tied 0 -> mem_req high exactly 4 cycles, then valid=1, err=1, rdata=0; ack on 4th cycle instead -> err=0 with the data.
6. rst_n pulled low during BUS -> mem_req, busy, valid go 0 immediately (asynchronously); after release, a new LW completes normally; start asserted during BUS/DONE is ignored (one valid per accepted request).
